cosine_nco: RTL and testbench

Multi-channel, parametrised carrier generator that succeeds the fixed-index cosine lookup. Each channel owns a phase accumulator with a programmable step and phase offset. A quarter-wave cosine table, shared by all channels, converts phase to a signed fixed-point sample through a 3-stage pipeline. It sits between the modem control logic and the BPSK mixer, supplying per-channel carriers; a 180° offset yields the BPSK-inverted carrier.

---
 rtl/cosine_nco_if.sv | 33 +++
 rtl/cosine_nco.sv | 137 +++++++++++++
 tb/tb_cosine_nco.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cosine_nco_if.sv
// cosine_nco_if: control and sample bus between the modem control logic (master)
// and the cosine NCO (slave). sin_out exists only when COSINE_NCO_QUAD_EN is defined.
interface cosine_nco_if #(
    parameter int CHANNELS  = 2,
    parameter int PW        = 6,
    parameter int OUT_WIDTH = 18
);
    logic                          en;
    logic                          sync;
    logic [CHANNELS*PW-1:0]        step;
    logic [CHANNELS*PW-1:0]        offset;
    logic [CHANNELS*OUT_WIDTH-1:0] out;
    logic                          out_valid;
`ifdef COSINE_NCO_QUAD_EN
    logic [CHANNELS*OUT_WIDTH-1:0] sin_out;
`endif

    modport master (
        output en, sync, step, offset,
        input  out, out_valid
`ifdef COSINE_NCO_QUAD_EN
        , input sin_out
`endif
    );

    modport slave (
        input  en, sync, step, offset,
        output out, out_valid
`ifdef COSINE_NCO_QUAD_EN
        , output sin_out
`endif
    );
endinterface

// File: rtl/cosine_nco.sv
// cosine_nco: multi-channel phase-accumulator carrier generator. A quarter-wave
// cosine table shared by all channels is folded by quadrant and read through a
// 3-stage pipeline. Define COSINE_NCO_QUAD_EN to add the quadrature (sin_out) path.
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 64
`endif
`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 18
`endif

module cosine_nco #(
    parameter int CHANNELS  = 2,
    parameter int SAMPLES   = `CARRIER_SAMPLES_PER_PERIOD,
    parameter int OUT_WIDTH = `FIXDT_64_A_WIDTH
) (
    input logic         clk,
    input logic         rst,
    cosine_nco_if.slave bus
);
    localparam int PW     = $clog2(SAMPLES);
    localparam int QN     = SAMPLES / 4;
    localparam int AW     = PW - 1;           // table address spans 0..N/4 inclusive
    localparam int W      = OUT_WIDTH;
    localparam int STAGES = 3;

    typedef logic [QN:0][W-1:0] lut_t;

    // Quarter-wave table, evaluated at elaboration; it becomes a constant ROM.
    function automatic lut_t build_lut();
        lut_t t;
        real  amp, v;
        amp = 2.0 ** (W - 1) - 1.0;
        for (int k = 0; k <= QN; k++) begin
            v    = $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(SAMPLES)) * amp;
            t[k] = W'($rtoi(v + 0.5));
        end
        return t;
    endfunction

    localparam lut_t LUT = build_lut();

    // Quadrant fold: returns {negate, table address}. Odd quadrants mirror the
    // address, quadrants 1 and 2 negate the magnitude.
    function automatic logic [AW:0] fold(input logic [PW-1:0] i);
        logic [AW-1:0] a;
        a = AW'(i[PW-3:0]);
        if (i[PW-2]) a = AW'(QN) - a;
        return {i[PW-1] ^ i[PW-2], a};
    endfunction

    logic              launch;
    logic [STAGES:1]   vld_pipe;

    // sync wins over en: a sync cycle never launches a sample
    assign launch = bus.en & ~bus.sync;

    // valid bits follow each launched sample set through the three stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], launch};
    end

    assign bus.out_valid = vld_pipe[STAGES];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [PW-1:0] acc, idx_r, stp, off;
        logic [AW:0]   f_cos;
        logic [W-1:0]  lut_r, cos_r;
        logic          neg_r;

        assign stp   = bus.step[c*PW +: PW];
        assign off   = bus.offset[c*PW +: PW];
        assign f_cos = fold(idx_r);

        // phase accumulator: sync clears, en advances modulo N
        always_ff @(posedge clk or posedge rst) begin
            if (rst)          acc <= '0;
            else if (bus.sync) acc <= '0;
            else if (bus.en)   acc <= acc + stp;
        end

        // stage 1: capture the pre-increment phase plus offset
        always_ff @(posedge clk or posedge rst) begin
            if (rst)         idx_r <= '0;
            else if (launch) idx_r <= acc + off;
        end

        // stage 2: table read and quadrant sign
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lut_r <= '0;
                neg_r <= 1'b0;
            end else if (vld_pipe[1]) begin
                lut_r <= LUT[f_cos[AW-1:0]];
                neg_r <= f_cos[AW];
            end
        end

        // stage 3: apply sign; output holds between launched samples
        always_ff @(posedge clk or posedge rst) begin
            if (rst)              cos_r <= '0;
            else if (vld_pipe[2]) cos_r <= neg_r ? -lut_r : lut_r;
        end

        assign bus.out[c*W +: W] = cos_r;

`ifdef COSINE_NCO_QUAD_EN
        logic [PW-1:0] idx_s;
        logic [AW:0]   f_sin;
        logic [W-1:0]  lut_s_r, sin_r;
        logic          neg_s_r;

        // sin(i) = cos(i - N/4), folded from the same stage-1 phase
        assign idx_s = idx_r - PW'(QN);
        assign f_sin = fold(idx_s);

        // stage 2 (quadrature): table read and sign
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lut_s_r <= '0;
                neg_s_r <= 1'b0;
            end else if (vld_pipe[1]) begin
                lut_s_r <= LUT[f_sin[AW-1:0]];
                neg_s_r <= f_sin[AW];
            end
        end

        // stage 3 (quadrature): apply sign
        always_ff @(posedge clk or posedge rst) begin
            if (rst)              sin_r <= '0;
            else if (vld_pipe[2]) sin_r <= neg_s_r ? -lut_s_r : lut_s_r;
        end

        assign bus.sin_out[c*W +: W] = sin_r;
`endif
    end
endmodule

// File: tb/tb_cosine_nco.sv
// tb_cosine_nco: directed and randomized checks of cosine_nco against an ideal
// cosine model (math library values, per-cycle launch queue with 3-edge delay).
module tb_cosine_nco;
    localparam int CH = 2;
    localparam int N  = 64;
    localparam int PW = 6;
    localparam int W  = 18;
    localparam int M  = 131071;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cosine_nco_if #(.CHANNELS(CH), .PW(PW), .OUT_WIDTH(W)) bus ();

    cosine_nco #(.CHANNELS(CH), .SAMPLES(N), .OUT_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                 v;
        logic [CH-1:0][31:0]  c;
        logic [CH-1:0][31:0]  s;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    ent_t pq[$];
    int   acc[CH], stp[CH], off[CH];
    int   held_c[CH], held_s[CH];
    int   exp_v;
    int   vcount;

    // ideal sample for phase index i: round(cos or sin of 2*pi*i/N times M)
    function automatic int ideal(input int i, input bit quad);
        real ang, v;
        ang = 2.0 * 3.14159265358979323846 * real'(i) / real'(N);
        v   = (quad ? $sin(ang) : $cos(ang)) * real'(M);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        pq.delete();
        for (int c = 0; c < CH; c++) begin
            acc[c] = 0; held_c[c] = 0; held_s[c] = 0;
        end
        exp_v = 0;
    endtask

    // one clock: drive inputs, advance the model, check every output after the edge
    task automatic cycle(input bit e, input bit s);
        ent_t nw, old;
        int   i;
        @(negedge clk);
        bus.en   = e;
        bus.sync = s;
        nw.v = e && !s;
        for (int c = 0; c < CH; c++) begin
            bus.step[c*PW +: PW]   = PW'(stp[c]);
            bus.offset[c*PW +: PW] = PW'(off[c]);
            i = (acc[c] + off[c]) % N;
            nw.c[c] = ideal(i, 1'b0);
            nw.s[c] = ideal(i, 1'b1);
            if (s)      acc[c] = 0;
            else if (e) acc[c] = (acc[c] + stp[c]) % N;
        end
        pq.push_back(nw);
        @(posedge clk);
        exp_v = 0;
        if (pq.size() == 3) begin
            old   = pq.pop_front();
            exp_v = int'(old.v);
            if (old.v) begin
                vcount++;
                for (int c = 0; c < CH; c++) begin
                    held_c[c] = int'(old.c[c]);
                    held_s[c] = int'(old.s[c]);
                end
            end
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), exp_v);
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("out%0d", c), 32'($signed(bus.out[c*W +: W])), held_c[c]);
`ifdef COSINE_NCO_QUAD_EN
            chk($sformatf("sin%0d", c), 32'($signed(bus.sin_out[c*W +: W])), held_s[c]);
`endif
        end
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        for (int c = 0; c < CH; c++)
            chk($sformatf("rst_out%0d", c), 32'($signed(bus.out[c*W +: W])), 0);
        model_clear();
        bus.en = 1'b0;
        bus.sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0; bus.sync = 1'b0; bus.step = '0; bus.offset = '0;
        model_clear();
        for (int c = 0; c < CH; c++) begin stp[c] = 0; off[c] = 0; end
        pulse_reset();

        // channel 0 step 1 from phase 0; channel 1 is the 180-degree copy
        stp[0] = 1; off[0] = 0; stp[1] = 1; off[1] = 32; vcount = 0;
        for (int k = 0; k < 67; k++) begin
            cycle(1'b1, 1'b0);
            if (k == 1) chk("lat_edge2_valid", 32'(bus.out_valid), 0);
            if (k == 2) chk("lat_edge3_out0", 32'($signed(bus.out[0 +: W])), M);
            if (exp_v != 0) begin
                chk("bpsk", 32'($signed(bus.out[W +: W])), -32'($signed(bus.out[0 +: W])));
                case (vcount - 1)
                    0:  chk("s0",  32'($signed(bus.out[0 +: W])), M);
                    16: chk("s16", 32'($signed(bus.out[0 +: W])), 0);
                    32: chk("s32", 32'($signed(bus.out[0 +: W])), -M);
                    48: chk("s48", 32'($signed(bus.out[0 +: W])), 0);
                    64: chk("s64", 32'($signed(bus.out[0 +: W])), M);
                    default: ;
                endcase
            end
        end

        // sync together with en mid-run: no launch, in-flight samples still emerge
        cycle(1'b1, 1'b1);
        off[0] = 5; off[1] = 17;
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);

        // step 3 across the modulo-64 wrap
        cycle(1'b0, 1'b1);
        stp[0] = 3; off[0] = 0;
        for (int k = 0; k < 22; k++) cycle(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);

        // gapped enable pattern 1,0,1,1,0
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);

        // randomized steps, offsets, enables and syncs
        for (int k = 0; k < 300; k++) begin
            for (int c = 0; c < CH; c++) begin
                stp[c] = int'($urandom_range(0, N - 1));
                off[c] = int'($urandom_range(0, N - 1));
            end
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        // reset mid-stream, then restart from phase 0
        pulse_reset();
        stp[0] = 1; off[0] = 0; stp[1] = 1; off[1] = 0; vcount = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b0);
            if (k == 2) chk("post_rst_out0", 32'($signed(bus.out[0 +: W])), M);
`ifdef COSINE_NCO_QUAD_EN
            if (exp_v != 0 && vcount == 1)  chk("sin_s0",  32'($signed(bus.sin_out[0 +: W])), 0);
            if (exp_v != 0 && vcount == 17) chk("sin_s16", 32'($signed(bus.sin_out[0 +: W])), M);
`endif
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
